cmd_bus_tx: RTL and testbench

//   Transmitter for the 3-bit command bus (C0..C2 plus strobe CLK) read by the power-stage controller.

---
 rtl/cmd_bus_tx_if.sv | 26 ++
 rtl/cmd_bus_tx.sv | 152 +++++++++++++++
 tb/tb_cmd_bus_tx.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/cmd_bus_tx_if.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | cmd_bus_tx_if : command handshake and C0..C2/CLK pin group          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface cmd_bus_tx_if;
    logic       cmd_valid;
    logic [2:0] cmd_code;
    logic       cmd_ready;
    logic [2:0] o_bus;
    logic       o_clk;
    logic       o_busy;
    logic       o_done;

    modport master (
        output cmd_valid, cmd_code,
        input  cmd_ready, o_bus, o_clk, o_busy, o_done
    );

    modport slave (
        input  cmd_valid, cmd_code,
        output cmd_ready, o_bus, o_clk, o_busy, o_done
    );
endinterface
`default_nettype wire

// File: rtl/cmd_bus_tx.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | cmd_bus_tx : serialises one command code per handshake as 3-bit     |
// | symbols with a slow strobe for the power-stage controller.         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module cmd_bus_tx #(
    parameter int T_SETUP = 32,
    parameter int T_HIGH  = 64,
    parameter int T_HOLD  = 32,
    parameter int T_GAP   = 128
) (
    input  logic         clk,
    input  logic         rstn,
    cmd_bus_tx_if.slave  cmd_if
);

    localparam logic [15:0] c_setup_load = 16'(T_SETUP - 1);
    localparam logic [15:0] c_high_load  = 16'(T_HIGH - 1);
    localparam logic [15:0] c_hold_load  = 16'(T_HOLD - 1);
    localparam logic [15:0] c_gap_load   = 16'(T_GAP - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t      r_state, w_state;
    logic [15:0] r_cnt,   w_cnt;
    logic [2:0]  r_idx,   w_idx;
    logic [2:0]  r_len,   w_len;
    logic [14:0] r_frame, w_frame;
    logic [2:0]  r_bus,   w_bus;
    logic        r_clk,   w_clk;
    logic        r_done,  w_done;
    logic        w_cnt_zero;

    assign w_cnt_zero = (r_cnt == 16'd0);

    // Frame is a shift register: the current symbol always sits in bits [2:0].
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_idx   = r_idx;
        w_len   = r_len;
        w_frame = r_frame;
        w_bus   = r_bus;
        w_clk   = r_clk;
        w_done  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_bus = 3'd0;
                w_clk = 1'b0;
                if (cmd_if.cmd_valid) begin
                    w_state = ST_SETUP;
                    w_cnt   = c_setup_load;
                    w_idx   = 3'd0;
                    w_bus   = cmd_if.cmd_code;
                    if (cmd_if.cmd_code == 3'd7) begin
                        w_len   = 3'd5;
                        w_frame = {3'd1, 3'd0, 3'd7, 3'd0, 3'd7};
                    end else begin
                        w_len   = 3'd2;
                        w_frame = {9'd0, 3'd0, cmd_if.cmd_code};
                    end
                end
            end
            ST_SETUP: begin
                if (w_cnt_zero) begin
                    w_state = ST_HIGH;
                    w_cnt   = c_high_load;
                    w_clk   = 1'b1;
                end else begin
                    w_cnt = r_cnt - 16'd1;
                end
            end
            ST_HIGH: begin
                if (w_cnt_zero) begin
                    w_state = ST_HOLD;
                    w_cnt   = c_hold_load;
                    w_clk   = 1'b0;
                end else begin
                    w_cnt = r_cnt - 16'd1;
                end
            end
            ST_HOLD: begin
                if (w_cnt_zero) begin
                    if ((r_idx + 3'd1) < r_len) begin
                        w_state = ST_SETUP;
                        w_cnt   = c_setup_load;
                        w_idx   = r_idx + 3'd1;
                        w_frame = {3'd0, r_frame[14:3]};
                        w_bus   = r_frame[5:3];
                    end else begin
                        w_state = ST_GAP;
                        w_cnt   = c_gap_load;
                        w_bus   = 3'd0;
                    end
                end else begin
                    w_cnt = r_cnt - 16'd1;
                end
            end
            ST_GAP: begin
                if (w_cnt_zero) begin
                    w_state = ST_IDLE;
                    w_done  = 1'b1;
                end else begin
                    w_cnt = r_cnt - 16'd1;
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_bus   = 3'd0;
                w_clk   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_cnt   <= 16'd0;
            r_idx   <= 3'd0;
            r_len   <= 3'd0;
            r_frame <= 15'd0;
            r_bus   <= 3'd0;
            r_clk   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_idx   <= w_idx;
            r_len   <= w_len;
            r_frame <= w_frame;
            r_bus   <= w_bus;
            r_clk   <= w_clk;
            r_done  <= w_done;
        end
    end

    assign cmd_if.cmd_ready = (r_state == ST_IDLE);
    assign cmd_if.o_busy    = (r_state != ST_IDLE);
    assign cmd_if.o_bus     = r_bus;
    assign cmd_if.o_clk     = r_clk;
    assign cmd_if.o_done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cmd_bus_tx.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | tb_cmd_bus_tx : randomized scoreboard bench for cmd_bus_tx          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_cmd_bus_tx;

    localparam int T_SETUP = 2;
    localparam int T_HIGH  = 4;
    localparam int T_HOLD  = 2;
    localparam int T_GAP   = 8;
    localparam int P       = T_SETUP + T_HIGH + T_HOLD;

    typedef struct {
        int sym;
        int cyc;
    } strobe_t;

    logic clk = 1'b0;
    logic rstn;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   next_free = 0;
    strobe_t exp_q[$];
    int      done_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cmd_bus_tx_if cif();

    cmd_bus_tx #(
        .T_SETUP (T_SETUP),
        .T_HIGH  (T_HIGH),
        .T_HOLD  (T_HOLD),
        .T_GAP   (T_GAP)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .cmd_if (cif)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Reference: frame contents and absolute event times derived from the accept cycle.
    task automatic model_accept(input int code, input int c0);
        int syms[$];
        if (code == 7) syms = '{7, 0, 7, 0, 1};
        else           syms = '{code, 0};
        foreach (syms[k]) begin
            strobe_t e;
            e.sym = syms[k];
            e.cyc = c0 + 1 + k * P + T_SETUP + T_HIGH;
            exp_q.push_back(e);
        end
        next_free = c0 + 1 + syms.size() * P + T_GAP;
        done_q.push_back(next_free);
    endtask

    task automatic issue(input bit v, input int code);
        int c;
        c = code & 7;
        @(negedge clk);
        #1;
        cif.cmd_valid = v;
        cif.cmd_code  = c[2:0];
        if (v && cif.cmd_ready && rstn) model_accept(c, cyc);
    endtask

    // Monitor
    initial begin
        logic       prev_clk;
        logic [2:0] prev_bus;
        prev_clk = 1'b0;
        prev_bus = 3'd0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_clk = 1'b0;
                prev_bus = 3'd0;
                continue;
            end
            chk("ready", int'(cif.cmd_ready), int'(cyc >= next_free));
            chk("busy", int'(cif.o_busy), int'(cyc < next_free));
            if (cif.o_bus != prev_bus && (cif.o_clk || prev_clk))
                chk("bus_stable", int'(cif.o_bus), int'(prev_bus));
            if (prev_clk && !cif.o_clk) begin
                if (exp_q.size() == 0) begin
                    chk("strobe_unexpected", 1, 0);
                end else begin
                    strobe_t e;
                    e = exp_q.pop_front();
                    chk("strobe_sym", int'(cif.o_bus), e.sym);
                    chk("strobe_cycle", cyc, e.cyc);
                end
            end
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                chk("strobe_missing", cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (cif.o_done) begin
                if (done_q.size() == 0) chk("done_unexpected", 1, 0);
                else                    chk("done_cycle", cyc, done_q.pop_front());
            end
            if (done_q.size() > 0 && done_q[0] < cyc) begin
                chk("done_missing", cyc, done_q[0]);
                void'(done_q.pop_front());
            end
            prev_clk = cif.o_clk;
            prev_bus = cif.o_bus;
        end
    end

    // Stimulus
    initial begin
        int n;
        rstn = 1'b1;
        cif.cmd_valid = 1'b0;
        cif.cmd_code  = 3'd0;
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_ready", int'(cif.cmd_ready), 1);
        chk("rst_bus", int'(cif.o_bus), 0);
        chk("rst_clk", int'(cif.o_clk), 0);
        chk("rst_busy", int'(cif.o_busy), 0);
        chk("rst_done", int'(cif.o_done), 0);
        repeat (3) @(negedge clk);
        #1;
        rstn = 1'b1;

        issue(1, 1);
        repeat (30) issue(0, int'($urandom));
        issue(1, 7);
        repeat (55) issue(0, 0);
        repeat (40) issue(1, 3);
        issue(1, 2);
        repeat (4) issue(0, 0);
        issue(1, 5);
        repeat (25) issue(0, 0);

        // Reset while the strobe is high
        issue(1, 6);
        n = 0;
        while (!cif.o_clk && n < 50) begin
            issue(0, 0);
            n++;
        end
        chk("strobe_seen_before_reset", int'(cif.o_clk), 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("midrst_clk", int'(cif.o_clk), 0);
        chk("midrst_bus", int'(cif.o_bus), 0);
        chk("midrst_ready", int'(cif.cmd_ready), 1);
        chk("midrst_busy", int'(cif.o_busy), 0);
        exp_q.delete();
        done_q.delete();
        next_free = 0;
        repeat (2) @(negedge clk);
        #1;
        rstn = 1'b1;

        repeat (1500) issue($urandom_range(0, 3) == 0, int'($urandom_range(0, 7)));

        n = 0;
        while ((exp_q.size() + done_q.size()) != 0 && n < 200) begin
            issue(0, 0);
            n++;
        end
        chk("drain", exp_q.size() + done_q.size(), 0);
        repeat (3) issue(0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
